arb_requester: RTL

- Initiator-side agent for one port of the round-robin arbiter.
- Queues burst commands from a local client and drives that port's request line.
- Each grant cycle from the arbiter issues exactly one beat of the head burst. The burst is retired after its final beat.
- One instance is placed per arbiter port; its req/gnt pair connects to bit i of the arbiter's req/gnt vectors.

---
 rtl/arb_requester.sv | 93 +++++++++
 1 files changed

// File: rtl/arb_requester.sv
// Initiator-side agent for one round-robin arbiter port: queues burst commands
// and issues one beat of the head burst per grant cycle.
module arb_requester #(
  parameter int DEPTH = 4,
  parameter int DW    = 8,
  parameter int LW    = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_valid,
  output logic                     push_ready,
  input  logic [DW-1:0]            push_data,
  input  logic [LW-1:0]            push_len,
  output logic                     req,
  input  logic                     gnt,
  output logic                     out_valid,
  output logic [DW-1:0]            out_data,
  output logic [LW-1:0]            out_beat,
  output logic                     out_last,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     gnt_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DW-1:0] mem_data [DEPTH];
  logic [LW-1:0] mem_len  [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] beat;

  logic do_push;
  logic do_issue;
  logic head_last;
  logic do_pop;

  // push_ready ignores a same-cycle pop, so a full queue never pushes through
  assign push_ready = (count != CW'(DEPTH));
  assign req        = (count != '0);
  assign do_push    = push_valid && push_ready;
  assign do_issue   = gnt && req;
  assign head_last  = (beat == mem_len[rd_ptr]);
  assign do_pop     = do_issue && head_last;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_data[wr_ptr] <= push_data;
      mem_len[wr_ptr]  <= push_len;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      beat      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_beat  <= '0;
      out_last  <= 1'b0;
      gnt_err   <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end

      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase

      // The beat counter only moves on an issue, so an interrupted burst resumes where it left off
      out_valid <= do_issue;
      if (do_issue) begin
        out_data <= mem_data[rd_ptr];
        out_beat <= beat;
        out_last <= head_last;
        beat     <= head_last ? '0 : beat + LW'(1);
      end

      if (gnt && !req) begin
        gnt_err <= 1'b1;
      end
    end
  end

endmodule
